// File: rtl/imm_gen_pipe.sv
// RV immediate generator with a 2-entry output buffer.
// Decodes I/S/B/U/J immediates and counts unsupported opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t     dec;
    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic [6:0] opcode;

    assign opcode = instruction[6:0];

    always_comb begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        unique case (opcode)
            7'b0000011,
            7'b0010011,
            7'b0011011,
            7'b1100111: dec.fmt = FMT_I;
            7'b0100011: dec.fmt = FMT_S;
            7'b1100011: dec.fmt = FMT_B;
            7'b0110111,
            7'b0010111: dec.fmt = FMT_U;
            7'b1101111: dec.fmt = FMT_J;
            7'b0110011,
            7'b0111011,
            7'b1110011,
            7'b0001111: dec.fmt = FMT_NONE;
            default:    dec.illegal = 1'b1;
        endcase
    end

    // Fill with the sign bit, then overwrite the low bits per format.
    always_comb begin
        dec.imm = '0;
        unique case (dec.fmt)
            FMT_I: begin
                dec.imm = {XLEN{instruction[31]}};
                dec.imm[11:0] = instruction[31:20];
            end
            FMT_S: begin
                dec.imm = {XLEN{instruction[31]}};
                dec.imm[11:0] = {instruction[31:25], instruction[11:7]};
            end
            FMT_B: begin
                dec.imm = {XLEN{instruction[31]}};
                dec.imm[12:0] = {instruction[31], instruction[7],
                                 instruction[30:25], instruction[11:8],
                                 1'b0};
            end
            FMT_U: begin
                dec.imm = {XLEN{instruction[31]}};
                dec.imm[31:0] = {instruction[31:12], 12'b0};
            end
            FMT_J: begin
                dec.imm = {XLEN{instruction[31]}};
                dec.imm[20:0] = {instruction[31], instruction[19:12],
                                 instruction[20], instruction[30:21],
                                 1'b0};
            end
            default: dec.imm = '0;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_imm     = mem[rd_ptr].imm;
    assign out_fmt     = mem[rd_ptr].fmt;
    assign out_illegal = mem[rd_ptr].illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (clr_cnt) begin
            illegal_cnt <= '0;
        end else if (push && dec.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode, buffering,
// back-pressure, counter saturation/clear and async reset.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic        clr_cnt;
    logic [15:0] illegal_cnt;

    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] instruction2;
    logic        out_valid2;
    logic [63:0] out_imm2;
    logic [2:0]  out_fmt2;
    logic        out_illegal2;
    logic [1:0]  illegal_cnt2;

    int total = 0;
    int bad   = 0;

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal),
        .clr_cnt(clr_cnt), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .instruction(instruction2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_imm(out_imm2), .out_fmt(out_fmt2),
        .out_illegal(out_illegal2),
        .clr_cnt(1'b0), .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag,
                              input logic [63:0] imm,
                              input logic [2:0]  fmt,
                              input logic        ill);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, out_imm, imm);
        check({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, "_ill"}, 64'(out_illegal), 64'(ill));
    endtask

    logic [31:0] b2b_inst [4];
    logic [63:0] b2b_imm  [4];
    logic [2:0]  b2b_fmt  [4];

    initial begin
        b2b_inst[0] = 32'h0020B423; b2b_imm[0] = 64'h0000000000000008; b2b_fmt[0] = 3'd2;
        b2b_inst[1] = 32'hFE000EE3; b2b_imm[1] = 64'hFFFFFFFFFFFFFFFC; b2b_fmt[1] = 3'd3;
        b2b_inst[2] = 32'h800002B7; b2b_imm[2] = 64'hFFFFFFFF80000000; b2b_fmt[2] = 3'd4;
        b2b_inst[3] = 32'h0040006F; b2b_imm[3] = 64'h0000000000000004; b2b_fmt[3] = 3'd5;

        rst_n = 1'b0;
        in_valid = 1'b0;
        instruction = 32'h0;
        out_ready = 1'b1;
        clr_cnt = 1'b0;
        in_valid2 = 1'b0;
        instruction2 = 32'h0;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_imm", out_imm, 64'd0);
        check("rst_fmt", 64'(out_fmt), 64'd0);
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();

        // single LD, one-cycle latency
        in_valid = 1'b1;
        instruction = 32'hFFF03083;
        step();
        in_valid = 1'b0;
        check_head("ld", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        step();
        check("ld_drain", 64'(out_valid), 64'd0);

        // back-to-back, one result per cycle
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instruction = b2b_inst[i];
            step();
            check_head($sformatf("b2b%0d", i), b2b_imm[i], b2b_fmt[i], 1'b0);
            check($sformatf("b2b%0d_rdy", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("b2b_drain", 64'(out_valid), 64'd0);

        // back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'h00100093;
        step();
        instruction = 32'hFFF00113;
        step();
        instruction = 32'h00001137;
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        check_head("bp_hold0", 64'd1, 3'd1, 1'b0);
        step();
        check("bp_full_rdy2", 64'(in_ready), 64'd0);
        check_head("bp_hold1", 64'd1, 3'd1, 1'b0);
        out_ready = 1'b1;
        step();
        check("bp_rdy_back", 64'(in_ready), 64'd1);
        check_head("bp_second", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        step();
        in_valid = 1'b0;
        check_head("bp_third", 64'h0000000000001000, 3'd4, 1'b0);
        step();
        check("bp_drain", 64'(out_valid), 64'd0);

        // no-immediate opcode is neither formatted nor illegal
        in_valid = 1'b1;
        instruction = 32'h00000033;
        step();
        in_valid = 1'b0;
        check_head("op_none", 64'd0, 3'd0, 1'b0);
        check("op_none_cnt", 64'(illegal_cnt), 64'd0);
        step();

        // illegal opcodes and counter clear priority
        in_valid = 1'b1;
        instruction = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            step();
            check_head($sformatf("ill%0d", i), 64'd0, 3'd0, 1'b1);
            check($sformatf("ill%0d_cnt", i), 64'(illegal_cnt), 64'(i + 1));
        end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        check("clr_cnt", 64'(illegal_cnt), 64'd0);
        check_head("ill_clr", 64'd0, 3'd0, 1'b1);
        step();

        // 2-bit counter saturates at 3
        in_valid2 = 1'b1;
        instruction2 = 32'h0000007F;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat%0d", i), 64'(illegal_cnt2),
                  64'((i < 3) ? i + 1 : 3));
        end
        in_valid2 = 1'b0;
        step();

        // async reset with a full buffer
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'h0000007F;
        step();
        instruction = 32'h00100093;
        step();
        in_valid = 1'b0;
        check("rst2_full", 64'(in_ready), 64'd0);
        check("rst2_cnt_pre", 64'(illegal_cnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_cnt", 64'(illegal_cnt), 64'd0);
        check("rst2_imm", out_imm, 64'd0);
        check("rst2_ill", 64'(out_illegal), 64'd0);
        step();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        instruction = 32'h00500093;
        step();
        in_valid = 1'b0;
        check_head("post_rst", 64'd5, 3'd1, 1'b0);
        step();
        check("post_rst_drain", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
